// File: rtl/ccc_apb_cfg_master_if.sv
// rtl/ccc_apb_cfg_master_if.sv - command/response, APB and PLL signal bundle for ccc_apb_cfg_master
interface ccc_apb_cfg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       BUSY;
  logic       LOCK;
  logic       PLL_ARST_N;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, PRDATA, BUSY, LOCK,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PLL_ARST_N
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, PRDATA, BUSY, LOCK,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PLL_ARST_N
  );
endinterface

// File: rtl/ccc_apb_cfg_master.sv
// rtl/ccc_apb_cfg_master.sv - APB configuration master for the CCC with PLL reload sequencing
// Optional macro CCC_CFG_READBACK_VERIFY_EN: every write is followed by a verifying read of the same address.
module ccc_apb_cfg_master #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int BUSY_TIMEOUT = 64
) (
  input logic                  PCLK,
  input logic                  PRESET_N,
  ccc_apb_cfg_master_if.master bus
);
  localparam int CNT_MAX = (LOCK_TIMEOUT > BUSY_TIMEOUT) ?
                           ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES) :
                           ((BUSY_TIMEOUT > RST_CYCLES) ? BUSY_TIMEOUT : RST_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_RELOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_PLLRST, S_LOCKWAIT, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [5:0]       r_addr;
  logic [7:0]       r_wdata;
  logic             r_pwrite, w_pwrite_nxt;
  logic             r_ready_en;
  logic             r_lock_meta, r_lock_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_rsp_rdata, w_rsp_rdata_nxt;
  logic             r_rsp_err, w_rsp_err_nxt;
  logic             w_accept;

  always_comb begin
    w_state_nxt     = r_state;
    w_pwrite_nxt    = r_pwrite;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_accept        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_ready_en) begin
          w_accept     = 1'b1;
          w_pwrite_nxt = (bus.cmd_op == OP_WRITE);
          case (bus.cmd_op)
            OP_WRITE, OP_READ: w_state_nxt = S_SETUP;
            OP_RELOAD:         w_state_nxt = S_PLLRST;
            default: begin
              w_state_nxt     = S_DONE;
              w_rsp_rdata_nxt = 8'h00;
              w_rsp_err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (!bus.BUSY) begin
          if (r_op == OP_READ) begin
            w_state_nxt     = S_DONE;
            w_rsp_rdata_nxt = bus.PRDATA;
            w_rsp_err_nxt   = 1'b0;
          end
`ifdef CCC_CFG_READBACK_VERIFY_EN
          // A write keeps PWRITE high only in its first access; PWRITE low marks the readback.
          else if (r_pwrite) begin
            w_state_nxt  = S_SETUP;
            w_pwrite_nxt = 1'b0;
          end else begin
            w_state_nxt     = S_DONE;
            w_rsp_rdata_nxt = bus.PRDATA;
            w_rsp_err_nxt   = (bus.PRDATA != r_wdata);
          end
`else
          else begin
            w_state_nxt     = S_DONE;
            w_rsp_rdata_nxt = r_wdata;
            w_rsp_err_nxt   = 1'b0;
          end
`endif
        end else if (r_cnt == BUSY_LAST) begin
          w_state_nxt     = S_DONE;
          w_rsp_rdata_nxt = 8'h00;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      S_PLLRST: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_LOCKWAIT;
      end
      S_LOCKWAIT: begin
        // Lock is tested first so it wins over a timeout in the same cycle.
        if (r_lock_sync) begin
          w_state_nxt     = S_DONE;
          w_rsp_rdata_nxt = 8'h00;
          w_rsp_err_nxt   = 1'b0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt     = S_DONE;
          w_rsp_rdata_nxt = 8'h00;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_addr      <= 6'd0;
      r_wdata     <= 8'd0;
      r_pwrite    <= 1'b0;
      r_ready_en  <= 1'b0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_cnt       <= '0;
      r_rsp_rdata <= 8'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_ready_en  <= 1'b1;
      r_lock_meta <= bus.LOCK;
      r_lock_sync <= r_lock_meta;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (w_accept) begin
        r_op    <= bus.cmd_op;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
      end
      // One shared counter: cleared on every state change, saturating otherwise.
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != '1)       r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE) && r_ready_en;
  assign bus.rsp_valid  = (r_state == S_DONE);
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.PSEL       = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign bus.PENABLE    = (r_state == S_ACCESS);
  assign bus.PWRITE     = r_pwrite;
  assign bus.PADDR      = r_addr;
  assign bus.PWDATA     = r_wdata;
  assign bus.PLL_ARST_N = (r_state != S_PLLRST);
endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// tb/tb_ccc_apb_cfg_master.sv - scoreboard bench for ccc_apb_cfg_master with CCC slave and PLL lock models
module tb_ccc_apb_cfg_master;
  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int BUSY_TIMEOUT = 64;
  localparam int NEVER        = 100000;

  logic PCLK = 1'b0;
  logic PRESET_N = 1'b0;

  ccc_apb_cfg_master_if bus();

  ccc_apb_cfg_master #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .PCLK    (PCLK),
    .PRESET_N(PRESET_N),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
    int         n_apb;
    int         n_rst;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         busy_req = 0;
  int         lock_delay = NEVER;
  logic       corrupt = 1'b0;
  logic [7:0] slave_mem [64];
  logic       mem_ready = 1'b0;
  logic [7:0] ref_mem [64];
  int         apb_done = 0;
  int         rst_low = 0;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  // CCC register file: writes land on the completing ACCESS edge, optionally with bit 0 flipped.
  assign bus.PRDATA = slave_mem[bus.PADDR];
  always @(posedge PCLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) slave_mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (bus.PSEL && bus.PENABLE && !bus.BUSY && bus.PWRITE) begin
      slave_mem[bus.PADDR] <= corrupt ? (bus.PWDATA ^ 8'h01) : bus.PWDATA;
    end
  end

  // Wait states: busy_req busy cycles in the first access of each command.
  initial begin
    int  busy_left;
    logic prev_pen;
    busy_left = 0;
    prev_pen  = 1'b0;
    bus.BUSY  = 1'b0;
    forever begin
      @(negedge PCLK);
      if (bus.PSEL && !bus.PENABLE && !prev_pen) busy_left = busy_req;
      prev_pen = bus.PENABLE;
      bus.BUSY = bus.PSEL && bus.PENABLE && (busy_left > 0);
      if (bus.BUSY) busy_left--;
    end
  end

  // PLL model: LOCK drops during reset and rises lock_delay negedges after release.
  initial begin
    logic lk_prev;
    int   lk_cnt;
    logic lk_armed;
    lk_prev  = 1'b1;
    lk_cnt   = 0;
    lk_armed = 1'b0;
    bus.LOCK = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!bus.PLL_ARST_N) begin
        bus.LOCK = 1'b0;
        lk_armed = 1'b0;
      end
      if (!lk_prev && bus.PLL_ARST_N) begin
        lk_armed = 1'b1;
        lk_cnt   = 0;
      end
      lk_prev = bus.PLL_ARST_N;
      if (lk_armed) begin
        if (lk_cnt == lock_delay) begin
          bus.LOCK = 1'b1;
          lk_armed = 1'b0;
        end else begin
          lk_cnt++;
        end
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each response.
  initial begin
    exp_t       e;
    logic [5:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_write;
    s_addr  = 6'd0;
    s_wdata = 8'd0;
    s_write = 1'b0;
    forever begin
      @(negedge PCLK);
      #1;
      if (!PRESET_N) begin
        sb.delete();
        apb_done = 0;
        rst_low  = 0;
      end else begin
        if (!bus.PLL_ARST_N) rst_low++;
        chk("apb_penable_without_psel", {31'd0, bus.PENABLE & ~bus.PSEL}, 0);
        if (bus.PSEL && !bus.PENABLE) begin
          s_addr  = bus.PADDR;
          s_wdata = bus.PWDATA;
          s_write = bus.PWRITE;
        end
        if (bus.PSEL && bus.PENABLE) begin
          chk("apb_stable", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {s_write, s_addr, s_wdata});
          if (!bus.BUSY) apb_done++;
        end
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", bus.rsp_err, e.err);
            chk("rsp_cycle", cyc, e.cyc);
            chk("apb_transfers", apb_done, e.n_apb);
            chk("pll_rst_cycles", rst_low, e.n_rst);
            chk("psel_in_done", {bus.PSEL, bus.PENABLE}, 2'b00);
          end
          apb_done = 0;
          rst_low  = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] wd,
                       input int k, input int d, input logic cor, input int hold);
    exp_t e;
    int   w;
    int   lat;
    w = 0;
    @(negedge PCLK);
    while (!bus.cmd_ready && w < 6000) begin
      @(negedge PCLK);
      w++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    if (!bus.cmd_ready) return;
    busy_req   = k;
    lock_delay = d;
    corrupt    = cor;
    e.rdata = 8'h00;
    e.err   = 1'b0;
    e.n_apb = 0;
    e.n_rst = 0;
    lat     = 0;
    case (op)
      2'b00, 2'b01: begin
        if (k >= BUSY_TIMEOUT) begin
          lat   = 1 + BUSY_TIMEOUT;
          e.err = 1'b1;
        end else if (op == 2'b01) begin
          lat     = 2 + k;
          e.rdata = ref_mem[addr];
          e.n_apb = 1;
        end else begin
          ref_mem[addr] = cor ? (wd ^ 8'h01) : wd;
`ifdef CCC_CFG_READBACK_VERIFY_EN
          lat     = 4 + k;
          e.rdata = ref_mem[addr];
          e.err   = cor;
          e.n_apb = 2;
`else
          lat     = 2 + k;
          e.rdata = wd;
          e.n_apb = 1;
`endif
        end
      end
      2'b10: begin
        e.n_rst = RST_CYCLES;
        if (d <= LOCK_TIMEOUT - 3) begin
          lat = RST_CYCLES + 3 + d;
        end else begin
          lat   = RST_CYCLES + LOCK_TIMEOUT;
          e.err = 1'b1;
        end
      end
      default: begin
        lat   = 0;
        e.err = 1'b1;
      end
    endcase
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    @(negedge PCLK);
    for (int h = 0; h < hold; h++) begin
      bus.cmd_op    = 2'b10;
      bus.cmd_addr  = ~addr;
      bus.cmd_wdata = ~wd;
      @(negedge PCLK);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PLL_ARST_N,
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready},
        {3'b000, 6'd0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
  endtask

  task automatic reset_pulse(input string name);
    @(negedge PCLK);
    PRESET_N = 1'b0;
    #1;
    chk_reset_outs(name);
    repeat (3) @(negedge PCLK);
    #1;
    chk_reset_outs("reset_hold");
    PRESET_N = 1'b1;
    #1;
    chk("cmd_ready_before_edge", bus.cmd_ready, 0);
    @(posedge PCLK);
    #1;
    chk("cmd_ready_first_edge", bus.cmd_ready, 1);
  endtask

  initial begin
    int w;
    int r;
    int kk;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 6'd0;
    bus.cmd_wdata = 8'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    PRESET_N = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    chk_reset_outs("reset_state");
    @(negedge PCLK);
    PRESET_N = 1'b1;
    #1;
    chk("cmd_ready_before_edge", bus.cmd_ready, 0);
    @(posedge PCLK);
    #1;
    chk("cmd_ready_first_edge", bus.cmd_ready, 1);

    issue(2'b00, 6'h15, 8'hA5, 0, NEVER, 1'b0, 0);
    issue(2'b01, 6'h15, 8'h00, 0, NEVER, 1'b0, 0);
    issue(2'b00, 6'h03, 8'h5C, 0, NEVER, 1'b0, 0);
    issue(2'b01, 6'h03, 8'h00, 3, NEVER, 1'b0, 0);
    issue(2'b01, 6'h07, 8'h00, 1000, NEVER, 1'b0, 0);
    issue(2'b01, 6'h3F, 8'h00, BUSY_TIMEOUT - 1, NEVER, 1'b0, 0);
    issue(2'b00, 6'h20, 8'h11, BUSY_TIMEOUT, NEVER, 1'b0, 0);
    issue(2'b01, 6'h20, 8'h00, 0, NEVER, 1'b0, 0);
    issue(2'b10, 6'h00, 8'h00, 0, 10, 1'b0, 0);
    issue(2'b10, 6'h00, 8'h00, 0, NEVER, 1'b0, 0);
    issue(2'b10, 6'h00, 8'h00, 0, LOCK_TIMEOUT - 3, 1'b0, 0);
    issue(2'b10, 6'h00, 8'h00, 0, LOCK_TIMEOUT - 2, 1'b0, 0);
    issue(2'b11, 6'h09, 8'h77, 0, NEVER, 1'b0, 0);
    issue(2'b00, 6'h2A, 8'hA5, 0, NEVER, 1'b1, 0);
    issue(2'b01, 6'h2A, 8'h00, 0, NEVER, 1'b0, 0);
    issue(2'b01, 6'h05, 8'h00, 3, NEVER, 1'b0, 3);

    issue(2'b01, 6'h11, 8'h00, 40, NEVER, 1'b0, 0);
    repeat (4) @(negedge PCLK);
    #1;
    chk("in_access_before_reset", {bus.PSEL, bus.PENABLE}, 2'b11);
    reset_pulse("reset_mid_access");

    issue(2'b10, 6'h00, 8'h00, 0, NEVER, 1'b0, 0);
    repeat (4) @(negedge PCLK);
    #1;
    chk("in_pllrst_before_reset", bus.PLL_ARST_N, 0);
    reset_pulse("reset_mid_pllrst");

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r < 15)      kk = $urandom_range(0, 4);
      else if (r < 17) kk = BUSY_TIMEOUT - 1;
      else if (r < 19) kk = BUSY_TIMEOUT;
      else             kk = 200;
      r = $urandom_range(0, 9);
      issue((r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11,
            6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), kk,
            $urandom_range(0, 30), ($urandom_range(0, 7) == 0), 0);
    end

    w = 0;
    while (sb.size() != 0 && w < 6000) begin
      @(negedge PCLK);
      w++;
    end
    repeat (3) @(negedge PCLK);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ccc_apb_cfg_master.md
CCC_APB_CFG_MASTER -- requirements
Module: ccc_apb_cfg_master

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles PLL_ARST_N is held low during a PLL reload; legal range 1..255.
REQ-002 Parameter LOCK_TIMEOUT, default 4096: maximum cycles spent waiting for synchronized LOCK after a reload.
REQ-003 Parameter BUSY_TIMEOUT, default 64: maximum ACCESS cycles with BUSY=1 before the transfer is aborted.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; PCLK in 1: clock.
REQ-005 PRESET_N  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_op  in  2  command: 00 write, 01 read, 10 PLL reload, 11 reserved.
REQ-009 cmd_addr  in  6  CCC configuration register address.
REQ-010 cmd_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  8  read or readback data.
REQ-013 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB control to the CCC.
REQ-015 PADDR  out  6; PWDATA  out  8; PRDATA  in  8  APB address and data.
REQ-016 BUSY  in  1  CCC busy / wait-state; LOCK  in  1  PLL lock, asynchronous; PLL_ARST_N  out  1  PLL reset, active low.

Function
REQ-017 States SHALL be IDLE, SETUP, ACCESS, PLLRST, LOCKWAIT and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-018 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op, cmd_addr and cmd_wdata SHALL be registered on acceptance.
REQ-019 cmd_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-020 For write or read, SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0, and PADDR, PWDATA and PWRITE valid.
REQ-021 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL complete on the first cycle with BUSY=0; PADDR, PWDATA and PWRITE SHALL be stable through SETUP and ACCESS.
REQ-022 Read data SHALL be captured from PRDATA on the completing ACCESS edge.
REQ-023 PSEL and PENABLE SHALL be 0 in every state other than SETUP and ACCESS.
REQ-024 Latency with BUSY=0: acceptance at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3; cmd_ready SHALL return to 1 in cycle N+4.
REQ-025 After BUSY_TIMEOUT consecutive ACCESS cycles with BUSY=1, the transfer SHALL be aborted and the block SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-026 For a reload, the block SHALL enter PLLRST, drive PLL_ARST_N=0 for exactly RST_CYCLES cycles, then enter LOCKWAIT with PLL_ARST_N=1.
REQ-027 LOCK SHALL pass through a two-flop synchronizer.
REQ-028 LOCKWAIT SHALL exit to DONE with rsp_err=0 on synchronized LOCK=1, or with rsp_err=1 after LOCK_TIMEOUT cycles; on a simultaneous lock and timeout in the same cycle, lock SHALL win.
REQ-029 A reload SHALL produce no APB activity and SHALL return rsp_rdata=0.
REQ-030 cmd_op=11 SHALL go directly to DONE with rsp_err=1, with no APB activity and no change to PLL_ARST_N.
REQ-031 DONE SHALL last one cycle and assert rsp_valid=1; rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.
REQ-032 Timeout counters SHALL saturate and SHALL not wrap; they SHALL clear on entry to their state.

Reset
REQ-033 Asserting PRESET_N=0 SHALL immediately force IDLE and these output values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PLL_ARST_N=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and cmd_ready=0; the synchronizer and all counters SHALL also clear.
REQ-034 cmd_ready SHALL become 1 on the first PCLK edge after PRESET_N deasserts.
REQ-035 A reset during any in-flight command SHALL abort it with no rsp_valid, and PLL_ARST_N SHALL return to 1 asynchronously.

Configuration
REQ-036 With CCC_CFG_READBACK_VERIFY_EN defined, each write SHALL be followed by an automatic SETUP/ACCESS read of the same address.
REQ-037 With CCC_CFG_READBACK_VERIFY_EN defined, rsp_rdata SHALL equal the readback value, rsp_err SHALL be 1 if readback differs from the written data, and write latency SHALL increase by 2 cycles (rsp_valid at N+5).
REQ-038 Without CCC_CFG_READBACK_VERIFY_EN, a write SHALL perform one APB access and return rsp_rdata equal to the written data with rsp_err=0 (unless BUSY times out).

Verification
REQ-039 Write addr 0x15, data 0xA5, BUSY=0 -> a single APB write of PADDR=0x15, PWDATA=0xA5, with rsp_valid at N+3 and rsp_err=0.
REQ-040 Read addr 0x03, BUSY=1 for 3 ACCESS cycles, PRDATA=0x5C -> ACCESS lasts 4 cycles, rsp_rdata=0x5C, rsp_err=0.
REQ-041 Read with BUSY stuck at 1 -> abort after 64 ACCESS cycles with PSEL=0, rsp_err=1, rsp_rdata=0.
REQ-042 Reload with LOCK rising 10 cycles after PLL_ARST_N releases -> PLL_ARST_N low for 16 cycles, rsp_err=0; with LOCK held at 0 -> rsp_err=1 after 4096 cycles.
REQ-043 PRESET_N pulsed low mid-ACCESS and mid-PLLRST -> outputs take their reset values immediately, PLL_ARST_N=1, and no rsp_valid is produced.
REQ-044 With the macro defined, a CCC model returning 0xA4 for a write of 0xA5 -> a second APB read occurs, rsp_rdata=0xA4, rsp_err=1.
